// File: rtl/qspi_tx_byte_fifo_if.sv
// Bundle of DMA write, status and serializer byte handshake signals for the QSPI TX FIFO.
// slave = FIFO side, master = DMA/serializer (or bench) side.
interface qspi_tx_byte_fifo_if #(
    parameter int LEVEL_WIDTH = 5
);
    logic                   flush_i;
    logic                   msb_first_i;
    logic [31:0]            wr_data_i;
    logic                   wr_en_i;
    logic [LEVEL_WIDTH-1:0] level_o;
    logic                   full_o;
    logic                   empty_o;
    logic                   overflow_o;
    logic [7:0]             byte_o;
    logic                   byte_valid_o;
    logic                   byte_ready_i;

    modport slave (
        input  flush_i, msb_first_i, wr_data_i, wr_en_i, byte_ready_i,
        output level_o, full_o, empty_o, overflow_o, byte_o, byte_valid_o
    );

    modport master (
        output flush_i, msb_first_i, wr_data_i, wr_en_i, byte_ready_i,
        input  level_o, full_o, empty_o, overflow_o, byte_o, byte_valid_o
    );
endinterface

// File: rtl/qspi_tx_byte_fifo.sv
// Word-in / byte-out TX FIFO: 32-bit DMA words in, head word served a byte at a time.
// A word is popped only when its 4th byte is handed off, so level counts partial words.
module qspi_tx_byte_fifo #(
    parameter int DEPTH       = 16,
    parameter int LEVEL_WIDTH = 5
) (
    input  logic               clk,
    input  logic               resetn,
    qspi_tx_byte_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]            r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [LEVEL_WIDTH-1:0] r_level;
    logic [1:0]             r_byte_idx;
    logic                   r_overflow;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_wr_acc;
    logic                   w_xfer;
    logic                   w_pop;
    logic [1:0]             w_sel;
    logic [3:0][7:0]        w_lanes;

    // Status comes only from the registered level: no path from wr_en/ready.
    assign w_full   = (r_level == LEVEL_WIDTH'(DEPTH));
    assign w_empty  = (r_level == '0);
    assign w_wr_acc = bus.wr_en_i & ~w_full & ~bus.flush_i;
    assign w_xfer   = ~w_empty & bus.byte_ready_i & ~bus.flush_i;
    assign w_pop    = w_xfer & (r_byte_idx == 2'd3);

    assign w_lanes  = r_mem[r_rd_ptr];
    assign w_sel    = bus.msb_first_i ? (2'd3 - r_byte_idx) : r_byte_idx;

    assign bus.level_o      = r_level;
    assign bus.full_o       = w_full;
    assign bus.empty_o      = w_empty;
    assign bus.overflow_o   = r_overflow;
    assign bus.byte_valid_o = ~w_empty;
    assign bus.byte_o       = w_empty ? 8'h00 : w_lanes[w_sel];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= bus.wr_data_i;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_byte_idx <= '0;
            r_overflow <= 1'b0;
        end else if (bus.flush_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_byte_idx <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (bus.wr_en_i && w_full) r_overflow <= 1'b1;
            if (w_xfer) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_acc, w_pop})
                2'b10:   r_level <= r_level + LEVEL_WIDTH'(1);
                2'b01:   r_level <= r_level - LEVEL_WIDTH'(1);
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: tb/tb_qspi_tx_byte_fifo.sv
// Bench for qspi_tx_byte_fifo: vector table, directed corner sequences, random vs queue model.
module tb_qspi_tx_byte_fifo;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    qspi_tx_byte_fifo_if #(.LEVEL_WIDTH(LW)) bus ();

    qspi_tx_byte_fifo #(.DEPTH(DEPTH), .LEVEL_WIDTH(LW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    // Reference model: a word queue plus the index of the next byte of the head word.
    logic [31:0] mq[$];
    int          mb;
    bit          movf;

    typedef struct {
        bit          we;
        logic [31:0] wd;
        bit          rdy;
        bit          msb;
        int          lvl;
        bit          emp;
        bit          ful;
        bit          ovf;
        bit          bv;
        logic [7:0]  byt;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic mreset();
        mq.delete();
        mb   = 0;
        movf = 0;
    endtask

    task automatic mstep(input bit fl, input bit we, input logic [31:0] wd, input bit rdy);
        bit full;
        bit emp;
        if (fl) begin
            mreset();
            return;
        end
        full = (mq.size() == DEPTH);
        emp  = (mq.size() == 0);
        if (!emp && rdy) begin
            if (mb == 3) begin
                void'(mq.pop_front());
                mb = 0;
            end else mb++;
        end
        if (we) begin
            if (full) movf = 1;
            else mq.push_back(wd);
        end
    endtask

    function automatic logic [7:0] mbyte();
        int k;
        if (mq.size() == 0) return 8'h00;
        k = bus.msb_first_i ? 3 - mb : mb;
        return 8'((mq[0] >> (8 * k)) & 32'hff);
    endfunction

    task automatic cmp_all(input string tag);
        chk({tag, ".level"}, 32'(bus.level_o), 32'(mq.size()));
        chk({tag, ".empty"}, 32'(bus.empty_o), 32'(mq.size() == 0));
        chk({tag, ".full"},  32'(bus.full_o),  32'(mq.size() == DEPTH));
        chk({tag, ".ovf"},   32'(bus.overflow_o), 32'(movf));
        chk({tag, ".valid"}, 32'(bus.byte_valid_o), 32'(mq.size() != 0));
        chk({tag, ".byte"},  32'(bus.byte_o), 32'(mbyte()));
    endtask

    // Drive one cycle's inputs (called at negedge), advance model at posedge, compare at negedge.
    task automatic cyc(input bit fl, input bit we, input logic [31:0] wd, input bit rdy,
                       input string tag, input bit do_cmp = 1'b1);
        bus.flush_i      = fl;
        bus.wr_en_i      = we;
        bus.wr_data_i    = wd;
        bus.byte_ready_i = rdy;
        @(posedge clk);
        mstep(fl, we, wd, rdy);
        @(negedge clk);
        if (do_cmp) cmp_all(tag);
    endtask

    initial begin
        logic [31:0] first_w;
        bus.flush_i      = 1'b0;
        bus.msb_first_i  = 1'b0;
        bus.wr_data_i    = '0;
        bus.wr_en_i      = 1'b0;
        bus.byte_ready_i = 1'b0;
        mreset();

        // Reset values.
        #12;
        chk("rst.level", 32'(bus.level_o), 0);
        chk("rst.full",  32'(bus.full_o), 0);
        chk("rst.empty", 32'(bus.empty_o), 1);
        chk("rst.ovf",   32'(bus.overflow_o), 0);
        chk("rst.valid", 32'(bus.byte_valid_o), 0);
        chk("rst.byte",  32'(bus.byte_o), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Table: one word through in each byte order, ready held high.
        //                  we  wd            rdy msb lvl emp ful ovf bv  byte
        tbl.push_back('{1, 32'h44332211, 1, 0, 1, 0, 0, 0, 1, 8'h11});
        tbl.push_back('{0, 32'h0,        1, 0, 1, 0, 0, 0, 1, 8'h22});
        tbl.push_back('{0, 32'h0,        1, 0, 1, 0, 0, 0, 1, 8'h33});
        tbl.push_back('{0, 32'h0,        1, 0, 1, 0, 0, 0, 1, 8'h44});
        tbl.push_back('{0, 32'h0,        1, 0, 0, 1, 0, 0, 0, 8'h00});
        tbl.push_back('{1, 32'h44332211, 1, 1, 1, 0, 0, 0, 1, 8'h44});
        tbl.push_back('{0, 32'h0,        1, 1, 1, 0, 0, 0, 1, 8'h33});
        tbl.push_back('{0, 32'h0,        1, 1, 1, 0, 0, 0, 1, 8'h22});
        tbl.push_back('{0, 32'h0,        1, 1, 1, 0, 0, 0, 1, 8'h11});
        tbl.push_back('{0, 32'h0,        1, 1, 0, 1, 0, 0, 0, 8'h00});
        foreach (tbl[i]) begin
            string t;
            t = $sformatf("tbl%0d", i);
            bus.msb_first_i = tbl[i].msb;
            cyc(1'b0, tbl[i].we, tbl[i].wd, tbl[i].rdy, t, 1'b0);
            chk({t, ".level"}, 32'(bus.level_o), 32'(tbl[i].lvl));
            chk({t, ".empty"}, 32'(bus.empty_o), 32'(tbl[i].emp));
            chk({t, ".full"},  32'(bus.full_o),  32'(tbl[i].ful));
            chk({t, ".ovf"},   32'(bus.overflow_o), 32'(tbl[i].ovf));
            chk({t, ".valid"}, 32'(bus.byte_valid_o), 32'(tbl[i].bv));
            chk({t, ".byte"},  32'(bus.byte_o), 32'(tbl[i].byt));
        end
        bus.msb_first_i = 1'b0;

        // Fill to full, overflow on the 17th write, then drain all 64 bytes.
        first_w = $urandom;
        cyc(1'b0, 1'b1, first_w, 1'b0, "fill");
        for (int i = 1; i < DEPTH; i++) cyc(1'b0, 1'b1, $urandom, 1'b0, "fill");
        chk("full.level", 32'(bus.level_o), DEPTH);
        chk("full.full",  32'(bus.full_o), 1);
        cyc(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, "ovf");
        chk("ovf.flag",   32'(bus.overflow_o), 1);
        chk("ovf.level",  32'(bus.level_o), DEPTH);
        chk("ovf.head",   32'(bus.byte_o), 32'(first_w[7:0]));
        for (int i = 0; i < 4 * DEPTH; i++) cyc(1'b0, 1'b0, '0, 1'b1, "drain");
        chk("drain.level", 32'(bus.level_o), 0);
        chk("drain.empty", 32'(bus.empty_o), 1);

        // Full FIFO, pop and write in the same cycle: write is dropped.
        cyc(1'b1, 1'b0, '0, 1'b0, "flush0");
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, $urandom, 1'b0, "fill2");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1, "part");
        cyc(1'b0, 1'b1, 32'h12345678, 1'b1, "popwr");
        chk("popwr.level", 32'(bus.level_o), DEPTH - 1);
        chk("popwr.ovf",   32'(bus.overflow_o), 1);
        cyc(1'b1, 1'b1, 32'hCAFEF00D, 1'b1, "flush1");
        chk("flush.level", 32'(bus.level_o), 0);
        chk("flush.ovf",   32'(bus.overflow_o), 0);
        chk("flush.valid", 32'(bus.byte_valid_o), 0);

        // Level held at 5 by simultaneous pop+write, pointers wrapping past DEPTH.
        for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, $urandom, 1'b0, "pre");
        for (int i = 0; i < 56; i++) cyc(1'b0, 1'b0, '0, 1'b1, "pre_dr");
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, $urandom, 1'b0, "l5");
        for (int w = 0; w < 8; w++) begin
            for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 1'b1, "l5b");
            cyc(1'b0, 1'b1, $urandom, 1'b1, "l5pw");
            chk($sformatf("steady%0d.level", w), 32'(bus.level_o), 5);
        end
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, '0, 1'b1, "l5dr");
        chk("steady.empty", 32'(bus.empty_o), 1);

        // Asynchronous reset in the middle of a word.
        cyc(1'b0, 1'b1, 32'h55667788, 1'b0, "ar_w");
        cyc(1'b0, 1'b0, '0, 1'b1, "ar_b0");
        cyc(1'b0, 1'b0, '0, 1'b1, "ar_b1");
        chk("ar.byte_idx2", 32'(bus.byte_o), 32'h66);
        bus.byte_ready_i = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("ar.valid", 32'(bus.byte_valid_o), 0);
        chk("ar.level", 32'(bus.level_o), 0);
        mreset();
        @(negedge clk);
        resetn = 1'b1;
        cyc(1'b0, 1'b1, 32'hA1B2C3D4, 1'b0, "ar_new");
        chk("ar.newbyte", 32'(bus.byte_o), 32'hD4);
        cyc(1'b1, 1'b0, '0, 1'b0, "flush2");

        // Random traffic against the queue model.
        for (int i = 0; i < 2000; i++) begin
            bit fl, we, rdy;
            if (mq.size() == 0 && $urandom_range(7) == 0) bus.msb_first_i = ~bus.msb_first_i;
            fl  = ($urandom_range(63) == 0);
            we  = ($urandom_range(1) == 1);
            rdy = ($urandom_range(3) != 0);
            cyc(fl, we, $urandom, rdy, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
